// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings for the up/down counter's mode and direction controls.
package counter_pkg;
  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
endpackage

// File: rtl/updown_counter_gen_if.sv
// updown_counter_gen_if: control, bound and status signals of the bounded up/down counter.
interface updown_counter_gen_if #(parameter int SIZE = 8, parameter int STEP_W = 4);
  logic              ENABLE;
  logic              CONTROL;
  logic              MODE;
  logic [STEP_W-1:0] STEP;
  logic [SIZE-1:0]   LOWER;
  logic [SIZE-1:0]   UPPER;
  logic              LOAD;
  logic [SIZE-1:0]   LOAD_VALUE;
  logic              CLR_FLAGS;
  logic [SIZE-1:0]   COUNT;
  logic              AT_MAX;
  logic              AT_MIN;
  logic              OVF;
  logic              UNF;
  logic              OVF_STICKY;
  logic              UNF_STICKY;
  logic              CFG_ERR;
  modport master (
    output ENABLE, CONTROL, MODE, STEP, LOWER, UPPER, LOAD, LOAD_VALUE, CLR_FLAGS,
    input  COUNT, AT_MAX, AT_MIN, OVF, UNF, OVF_STICKY, UNF_STICKY, CFG_ERR
  );
  modport slave (
    input  ENABLE, CONTROL, MODE, STEP, LOWER, UPPER, LOAD, LOAD_VALUE, CLR_FLAGS,
    output COUNT, AT_MAX, AT_MIN, OVF, UNF, OVF_STICKY, UNF_STICKY, CFG_ERR
  );
endinterface

// File: rtl/counter_next_calc.sv
// counter_next_calc: combinational next-count and overflow/underflow events for one bounded step.
module counter_next_calc import counter_pkg::*; #(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic [SIZE-1:0]   count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [SIZE-1:0]   lower_i,
  input  logic [SIZE-1:0]   upper_i,
  input  logic              control_i,
  input  logic              mode_i,
  output logic [SIZE-1:0]   next_o,
  output logic              ovf_evt_o,
  output logic              unf_evt_o,
  output logic              out_of_range_o
);
  localparam int W = SIZE + 1;
  logic [W-1:0] sum, diff;
  logic oor_hi, oor_lo, up, hold, wrap, up_ok, dn_ok;
  // One extra bit keeps the carry/borrow so full-range bounds never alias.
  always_comb begin
    oor_hi         = count_i > upper_i;
    oor_lo         = count_i < lower_i;
    sum            = {1'b0, count_i} + W'(step_i);
    diff           = {1'b0, count_i} - W'(step_i);
    up             = control_i == DIR_UP;
    wrap           = mode_i == MODE_WRAP;
    hold           = step_i == '0;
    up_ok          = sum <= {1'b0, upper_i};
    dn_ok          = !diff[SIZE] && diff[SIZE-1:0] >= lower_i;
    out_of_range_o = oor_hi || oor_lo;
    ovf_evt_o      = !out_of_range_o && !hold && up && !up_ok;
    unf_evt_o      = !out_of_range_o && !hold && !up && !dn_ok;
    next_o         = oor_hi ? upper_i :
                     oor_lo ? lower_i :
                     hold   ? count_i :
                     up     ? (up_ok ? sum[SIZE-1:0] : (wrap ? lower_i : upper_i)) :
                              (dn_ok ? diff[SIZE-1:0] : (wrap ? upper_i : lower_i));
  end
endmodule

// File: rtl/updown_counter_gen.sv
// updown_counter_gen: bounded up/down counter with load, saturate/wrap modes and sticky flags.
module updown_counter_gen #(
  parameter int              SIZE      = 8,
  parameter int              STEP_W    = 4,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input logic                 CLOCK,
  input logic                 RESET,
  updown_counter_gen_if.slave bus
);
  logic [SIZE-1:0] count_q, count_d, nxt, load_val;
  logic ovf_q, ovf_d, unf_q, unf_d, ovfs_q, ovfs_d, unfs_q, unfs_d;
  logic cfg_err, cnt_en, ovf_evt, unf_evt, oor;
  counter_next_calc #(.SIZE(SIZE), .STEP_W(STEP_W)) u_calc (
    .count_i        (count_q),
    .step_i         (bus.STEP),
    .lower_i        (bus.LOWER),
    .upper_i        (bus.UPPER),
    .control_i      (bus.CONTROL),
    .mode_i         (bus.MODE),
    .next_o         (nxt),
    .ovf_evt_o      (ovf_evt),
    .unf_evt_o      (unf_evt),
    .out_of_range_o (oor)
  );
  // With inverted bounds there is no valid range, so loads pass through unclamped.
  always_comb begin
    cfg_err  = bus.LOWER > bus.UPPER;
    load_val = cfg_err                     ? bus.LOAD_VALUE :
               bus.LOAD_VALUE > bus.UPPER  ? bus.UPPER :
               bus.LOAD_VALUE < bus.LOWER  ? bus.LOWER : bus.LOAD_VALUE;
    cnt_en   = !bus.LOAD && bus.ENABLE && !cfg_err;
    count_d  = bus.LOAD ? load_val : cnt_en ? nxt : count_q;
    ovf_d    = cnt_en && !oor && ovf_evt;
    unf_d    = cnt_en && !oor && unf_evt;
    ovfs_d   = ovf_d || (ovfs_q && !bus.CLR_FLAGS);
    unfs_d   = unf_d || (unfs_q && !bus.CLR_FLAGS);
  end
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count_q <= RESET_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ovfs_q  <= 1'b0;
      unfs_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ovfs_q  <= ovfs_d;
      unfs_q  <= unfs_d;
    end
  end
  assign bus.COUNT      = count_q;
  assign bus.AT_MAX     = count_q == bus.UPPER;
  assign bus.AT_MIN     = count_q == bus.LOWER;
  assign bus.OVF        = ovf_q;
  assign bus.UNF        = unf_q;
  assign bus.OVF_STICKY = ovfs_q;
  assign bus.UNF_STICKY = unfs_q;
  assign bus.CFG_ERR    = cfg_err;
endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
Second-generation scalable up/down counter with programmable lower/upper bounds, programmable step, and runtime-selectable saturate or wrap mode. Adds synchronous load, boundary indicators, per-cycle overflow/underflow strobes and clearable sticky flags. Used wherever the design needs a bounded event/position counter that the plain saturating counter cannot express.

Parameters:
SIZE, 8, counter width in bits; COUNT, LOWER, UPPER and LOAD_VALUE are all SIZE bits, unsigned.
STEP_W, 4, width of the STEP input.
RESET_VAL, 0, value loaded into COUNT on reset.

Ports:
CLOCK  in  1  single clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
ENABLE  in  1  count enable.
CONTROL  in  1  direction: 1 = up, 0 = down.
MODE  in  1  0 = saturate, 1 = wrap.
STEP  in  STEP_W  increment/decrement magnitude.
LOWER  in  SIZE  lower bound, inclusive.
UPPER  in  SIZE  upper bound, inclusive.
LOAD  in  1  synchronous load strobe.
LOAD_VALUE  in  SIZE  value to load.
CLR_FLAGS  in  1  clears sticky flags.
COUNT  out  SIZE  registered count.
AT_MAX  out  1  combinational, COUNT == UPPER.
AT_MIN  out  1  combinational, COUNT == LOWER.
OVF  out  1  registered; high for the cycle after an up-step was clipped or wrapped.
UNF  out  1  registered; high for the cycle after a down-step was clipped or wrapped.
OVF_STICKY  out  1  registered sticky version of OVF.
UNF_STICKY  out  1  registered sticky version of UNF.
CFG_ERR  out  1  combinational, LOWER > UPPER.

Behaviour:
- Reset (RESET low, asynchronous):
  - COUNT = RESET_VAL.
  - OVF, UNF, OVF_STICKY and UNF_STICKY = 0.
  - Takes effect immediately, mid-operation included; the first update follows the first rising CLOCK after RESET deasserts.
- Per-edge priority: LOAD > count (ENABLE && !CFG_ERR) > hold.
- LOAD:
  - COUNT <= LOAD_VALUE clamped to [LOWER, UPPER].
  - If CFG_ERR, COUNT <= LOAD_VALUE unclamped.
  - OVF and UNF are 0 on the next cycle.
- Count operation, 1-cycle latency:
  - Arithmetic uses SIZE+1 bits so carry/borrow is never lost.
  - Out-of-bounds COUNT (bounds changed under it): if COUNT > UPPER or COUNT < LOWER, COUNT <= nearest bound. No OVF or UNF.
  - STEP == 0: hold; no flags.
  - Up: sum = COUNT + STEP.
    - sum <= UPPER: COUNT <= sum.
    - Otherwise OVF is set next cycle, and COUNT <= UPPER in saturate mode or LOWER in wrap mode. The remainder is discarded.
    - Already at UPPER in saturate mode: COUNT holds and OVF asserts on every enabled cycle.
  - Down: diff = COUNT - STEP.
    - No borrow and diff >= LOWER: COUNT <= diff.
    - Otherwise UNF is set next cycle, and COUNT <= LOWER in saturate mode or UPPER in wrap mode.
    - Already at LOWER in saturate mode: COUNT holds and UNF asserts on every enabled cycle.
- ENABLE low: COUNT holds; OVF and UNF are 0.
- CFG_ERR high: counting is inhibited and COUNT holds; LOAD still operates.
- OVF and UNF are single-cycle registered strobes, recomputed every edge.
- Sticky flags:
  - Set by the same condition that sets OVF/UNF.
  - Cleared by CLR_FLAGS.
  - Set and clear in the same cycle: set wins.
- Full range (LOWER = 0, UPPER = 2^SIZE−1) must be handled with no aliasing, e.g. 255 + 1 in wrap mode gives 0 with OVF.
- MODE, CONTROL, STEP and the bounds are sampled each edge; changing them takes effect on the next edge with no pipeline flush.

Decomposition:
- Shared package (counter_pkg):
  - MODE_SAT = 1'b0, MODE_WRAP = 1'b1.
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
- One natural sub-module, counter_next_calc:
  - Purely combinational, parametrised on SIZE and STEP_W.
  - Inputs: COUNT, STEP, LOWER, UPPER, CONTROL, MODE.
  - Outputs: next value, ovf_evt, unf_evt, out_of_range.
- The top level holds the registers, LOAD/ENABLE priority, clamp-on-load and sticky logic.

Test Plan:
1. Saturate up (SIZE=8): LOWER=10, UPPER=20, LOAD 18, STEP=3, up, MODE=0, ENABLE. Expect COUNT 18→20 with OVF=1 the cycle after; COUNT stays 20 and OVF stays 1 while enabled; AT_MAX=1; OVF_STICKY=1.
2. Wrap down: LOWER=10, UPPER=20, COUNT=11, STEP=2, down, MODE=1. Expect COUNT→20 with UNF pulse, then 18, 16; UNF=0 after the first cycle.
3. Load priority/clamp: UPPER=200, LOAD_VALUE=250, LOAD=1 and ENABLE=1 same cycle. Expect COUNT=200, OVF=0.
4. Full-range wrap: LOWER=0, UPPER=255, COUNT=255, STEP=1, up, MODE=1. Expect COUNT=0, OVF=1.
5. Sticky clear race: OVF event and CLR_FLAGS in the same cycle. Expect OVF_STICKY=1. Then CLR_FLAGS alone: OVF_STICKY=0.
6. Config error / async reset:
   - LOWER=30, UPPER=20, ENABLE=1: expect CFG_ERR=1 and COUNT holding.
   - Drop RESET mid-count between edges: expect COUNT=RESET_VAL and all flags 0 before the next CLOCK edge.
